// File: rtl/scr1_dbgc_hart_seq_pkg.sv
// Types and constants shared by the DBGC hart command sequencer slice.
package scr1_dbgc_hart_seq_pkg;

  localparam int unsigned SCR1_DBGC_DBG_CORE_INSTR_WIDTH = 32;

  // Single-beat DAP operations
  typedef enum logic [2:0] {
    OpRdState   = 3'd0,
    OpWrRunctrl = 3'd1,
    OpHalt      = 3'd2,
    OpRun       = 3'd3,
    OpExec      = 3'd4,
    OpRdDreg    = 3'd5,
    OpWrDreg    = 3'd6
  } type_scr1_dbgc_hart_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StExecRun,
    StExecWait,
    StResp
  } type_scr1_dbgc_hart_seq_fsm_e;

  typedef enum logic {
    ModeRun = 1'b0,
    ModeDbg = 1'b1
  } type_scr1_dbgc_hart_dbg_mode_e;

  typedef enum logic {
    FetchMem  = 1'b0,
    FetchDbgc = 1'b1
  } type_scr1_dbgc_fetch_src_e;

  // Bit 0 = irq_dsbl ... bit 3 = redirect_step
  typedef struct packed {
    logic                      redirect_step;
    logic                      pc_advmt_dsbl;
    type_scr1_dbgc_fetch_src_e fetch_src;
    logic                      irq_dsbl;
  } type_scr1_dbgc_hart_runctrl_s;

  typedef struct packed {
    logic except;
    logic halted;
  } type_scr1_dbgc_hart_state_s;

  localparam int unsigned HartRunctrlWidth = $bits(type_scr1_dbgc_hart_runctrl_s);
  localparam int unsigned HartStateWidth   = $bits(type_scr1_dbgc_hart_state_s);

endpackage

// File: rtl/scr1_dbgc_hart_seq_if.sv
// DAP-side single-beat operation/response channel of the hart sequencer.
interface scr1_dbgc_hart_seq_if
  import scr1_dbgc_hart_seq_pkg::*;
#(
  parameter int unsigned DWIDTH = 32
);
  logic                    dap_req;
  type_scr1_dbgc_hart_op_e dap_op;
  logic [DWIDTH-1:0]       dap_wdata;
  logic                    dap_ready;
  logic                    dap_resp_vld;
  logic                    dap_resp_err;
  logic [DWIDTH-1:0]       dap_rdata;

  modport master (
    output dap_req, dap_op, dap_wdata,
    input  dap_ready, dap_resp_vld, dap_resp_err, dap_rdata
  );

  modport slave (
    input  dap_req, dap_op, dap_wdata,
    output dap_ready, dap_resp_vld, dap_resp_err, dap_rdata
  );
endinterface

// File: rtl/scr1_dbgc_hart_seq_ddr.sv
// Core->DBGC debug data register: capture on core write, flag overwrite of unread data.
module scr1_dbgc_hart_seq_ddr #(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dreg_wr,
  input  logic [DWIDTH-1:0] dreg_in,
  input  logic              dreg_rd,
  output logic [DWIDTH-1:0] dreg,
  output logic              dreg_ovr
);

  logic [DWIDTH-1:0] dreg_q;
  logic              unread_q, unread_d;
  logic              ovr_q, ovr_d;

  // A read in the same cycle as a write consumes the old value: ovr stays clear,
  // the new value becomes unread.
  always_comb begin
    unread_d = unread_q;
    ovr_d    = ovr_q;
    if (dreg_rd) begin
      ovr_d    = 1'b0;
      unread_d = 1'b0;
    end else if (dreg_wr && unread_q) begin
      ovr_d = 1'b1;
    end
    if (dreg_wr) unread_d = 1'b1;
  end

  // Capture register and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dreg_q   <= '0;
      unread_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      if (dreg_wr) dreg_q <= dreg_in;
      unread_q <= unread_d;
      ovr_q    <= ovr_d;
    end
  end

  assign dreg     = dreg_q;
  assign dreg_ovr = ovr_q;

endmodule

// File: rtl/scr1_dbgc_hart_seq.sv
// DBGC hart command sequencer: DAP single-beat ops -> hart cmd/req/ack/nack handshake.
// Optional: SCR1_DBGC_CMD_TIMEOUT_EN adds an ACK_TIMEOUT-cycle ack/nack watchdog.
module scr1_dbgc_hart_seq
  import scr1_dbgc_hart_seq_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned DWIDTH      = 32
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  scr1_dbgc_hart_seq_if.slave                       dap,
  output type_scr1_dbgc_hart_dbg_mode_e             hart_cmd,
  output logic                                      hart_cmd_req,
  input  logic                                      hart_cmd_ack,
  input  logic                                      hart_cmd_nack,
  output type_scr1_dbgc_hart_runctrl_s              hart_runctrl,
  input  type_scr1_dbgc_hart_state_s                hart_state,
  output logic [SCR1_DBGC_DBG_CORE_INSTR_WIDTH-1:0] hart_instr,
  output logic [DWIDTH-1:0]                         hart_dreg_out,
  input  logic [DWIDTH-1:0]                         hart_dreg_in,
  input  logic                                      hart_dreg_wr
);

  type_scr1_dbgc_hart_seq_fsm_e state_q, state_d;
  type_scr1_dbgc_hart_dbg_mode_e cmd_q, cmd_d;
  type_scr1_dbgc_hart_runctrl_s runctrl_q, runctrl_d;
  type_scr1_dbgc_fetch_src_e fetch_save_q, fetch_save_d;
  logic                                      req_q, req_d;
  logic [SCR1_DBGC_DBG_CORE_INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [DWIDTH-1:0]                         dreg_out_q, dreg_out_d;
  logic [DWIDTH-1:0]                         rdata_q, rdata_d;
  logic                                      err_q, err_d;
  logic                                      vld_q;
  logic                                      wait_q, wait_d;
  logic                                      accept;
  logic                                      tmo_expired;
  logic [DWIDTH-1:0]                         dreg_cap;
  logic                                      dreg_ovr;

  assign accept = (state_q == StIdle) && dap.dap_req;

  scr1_dbgc_hart_seq_ddr #(
    .DWIDTH (DWIDTH)
  ) u_ddr (
    .clk      (clk),
    .rst_n    (rst_n),
    .dreg_wr  (hart_dreg_wr),
    .dreg_in  (hart_dreg_in),
    .dreg_rd  (accept && (dap.dap_op == OpRdDreg)),
    .dreg     (dreg_cap),
    .dreg_ovr (dreg_ovr)
  );

`ifdef SCR1_DBGC_CMD_TIMEOUT_EN
  localparam logic [7:0] AckTimeoutInit = 8'(ACK_TIMEOUT);
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       waiting_ack;

  assign waiting_ack = (state_q == StCmd) || (state_q == StExecRun);
  // Expires on the cycle the counter would reach zero
  assign tmo_expired = waiting_ack && (tmo_cnt_q == 8'd1);

  // Load on entry to a handshake state, count down while no ack/nack
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if ((state_q == StIdle) && ((state_d == StCmd) || (state_d == StExecRun))) begin
      tmo_cnt_d = AckTimeoutInit;
    end else if (waiting_ack && !hart_cmd_ack && !hart_cmd_nack && (tmo_cnt_q != 8'd0)) begin
      tmo_cnt_d = tmo_cnt_q - 8'd1;
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_expired = 1'b0;
`endif

  // Next-state and register updates for the operation sequencer
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    req_d        = req_q;
    runctrl_d    = runctrl_q;
    fetch_save_d = fetch_save_q;
    instr_d      = instr_q;
    dreg_out_d   = dreg_out_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    wait_d       = wait_q;
    unique case (state_q)
      StIdle: begin
        if (dap.dap_req) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = StResp;
          case (dap.dap_op)
            OpRdState: rdata_d = {dreg_ovr, {(DWIDTH - 1 - HartStateWidth){1'b0}}, hart_state};
            OpWrRunctrl: begin
              runctrl_d = type_scr1_dbgc_hart_runctrl_s'(dap.dap_wdata[HartRunctrlWidth-1:0]);
            end
            OpRdDreg: rdata_d = dreg_cap;
            OpWrDreg: dreg_out_d = dap.dap_wdata;
            OpHalt, OpRun: begin
              cmd_d   = (dap.dap_op == OpHalt) ? ModeDbg : ModeRun;
              req_d   = 1'b1;
              state_d = StCmd;
            end
            OpExec: begin
              // Debug fetch is only meaningful on a halted hart
              if (hart_state.halted) begin
                instr_d             = dap.dap_wdata[SCR1_DBGC_DBG_CORE_INSTR_WIDTH-1:0];
                fetch_save_d        = runctrl_q.fetch_src;
                runctrl_d.fetch_src = FetchDbgc;
                cmd_d               = ModeRun;
                req_d               = 1'b1;
                state_d             = StExecRun;
              end else begin
                err_d = 1'b1;
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      StCmd: begin
        // nack wins over a simultaneous ack
        if (hart_cmd_nack || hart_cmd_ack || tmo_expired) begin
          req_d   = 1'b0;
          err_d   = hart_cmd_nack || !hart_cmd_ack;
          state_d = StResp;
        end
      end
      StExecRun: begin
        if (hart_cmd_nack || (!hart_cmd_ack && tmo_expired)) begin
          req_d               = 1'b0;
          runctrl_d.fetch_src = fetch_save_q;
          err_d               = 1'b1;
          state_d             = StResp;
        end else if (hart_cmd_ack) begin
          req_d   = 1'b0;
          wait_d  = 1'b1;
          state_d = StExecWait;
        end
      end
      StExecWait: begin
        // One dead cycle so halted is not sampled until 2 cycles after ack
        if (wait_q) begin
          wait_d = 1'b0;
        end else if (hart_state.halted) begin
          runctrl_d.fetch_src = fetch_save_q;
          err_d               = hart_state.except;
          state_d             = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Hart-facing and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q        <= ModeRun;
      req_q        <= 1'b0;
      runctrl_q    <= '0;
      fetch_save_q <= FetchMem;
      instr_q      <= '0;
      dreg_out_q   <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      vld_q        <= 1'b0;
      wait_q       <= 1'b0;
    end else begin
      cmd_q        <= cmd_d;
      req_q        <= req_d;
      runctrl_q    <= runctrl_d;
      fetch_save_q <= fetch_save_d;
      instr_q      <= instr_d;
      dreg_out_q   <= dreg_out_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      vld_q        <= (state_q == StResp);
      wait_q       <= wait_d;
    end
  end

  assign dap.dap_ready    = accept;
  assign dap.dap_resp_vld = vld_q;
  assign dap.dap_resp_err = err_q;
  assign dap.dap_rdata    = rdata_q;
  assign hart_cmd         = cmd_q;
  assign hart_cmd_req     = req_q;
  assign hart_runctrl     = runctrl_q;
  assign hart_instr       = instr_q;
  assign hart_dreg_out    = dreg_out_q;

endmodule

// File: tb/tb_scr1_dbgc_hart_seq.sv
// Directed self-checking bench for scr1_dbgc_hart_seq (timeout scenario needs
// SCR1_DBGC_CMD_TIMEOUT_EN).
module tb_scr1_dbgc_hart_seq;
  import scr1_dbgc_hart_seq_pkg::*;

  localparam int unsigned DWIDTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scr1_dbgc_hart_seq_if #(.DWIDTH(DWIDTH)) dap ();

  type_scr1_dbgc_hart_dbg_mode_e hart_cmd;
  logic                          hart_cmd_req;
  logic                          hart_cmd_ack;
  logic                          hart_cmd_nack;
  type_scr1_dbgc_hart_runctrl_s  hart_runctrl;
  type_scr1_dbgc_hart_state_s    hart_state;
  logic [31:0]                   hart_instr;
  logic [DWIDTH-1:0]             hart_dreg_out;
  logic [DWIDTH-1:0]             hart_dreg_in;
  logic                          hart_dreg_wr;

  int checks = 0;
  int errors = 0;

  scr1_dbgc_hart_seq #(
    .ACK_TIMEOUT (4),
    .DWIDTH      (DWIDTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dap           (dap.slave),
    .hart_cmd      (hart_cmd),
    .hart_cmd_req  (hart_cmd_req),
    .hart_cmd_ack  (hart_cmd_ack),
    .hart_cmd_nack (hart_cmd_nack),
    .hart_runctrl  (hart_runctrl),
    .hart_state    (hart_state),
    .hart_instr    (hart_instr),
    .hart_dreg_out (hart_dreg_out),
    .hart_dreg_in  (hart_dreg_in),
    .hart_dreg_wr  (hart_dreg_wr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op in IDLE; it is accepted on the next edge
  task automatic issue(input type_scr1_dbgc_hart_op_e op, input logic [DWIDTH-1:0] wdata);
    dap.dap_req   = 1'b1;
    dap.dap_op    = op;
    dap.dap_wdata = wdata;
    step();
    dap.dap_req = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (dap.dap_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", dap.dap_ready); end
    checks++; if (dap.dap_resp_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", dap.dap_resp_vld); end
    checks++; if (dap.dap_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", dap.dap_rdata); end
    checks++; if (hart_cmd_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", hart_cmd_req); end
    checks++; if (hart_cmd !== ModeRun) begin errors++; $display("FAIL reset_cmd got %b want 0", hart_cmd); end
    checks++; if (hart_runctrl !== 4'h0) begin errors++; $display("FAIL reset_runctrl got %h want 0", hart_runctrl); end
    checks++; if ({hart_instr, hart_dreg_out} !== 64'h0) begin errors++; $display("FAIL reset_instr_dreg got %h want 0", {hart_instr, hart_dreg_out}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_rd_state();
    hart_state = '{except: 1'b1, halted: 1'b0};
    dap.dap_req = 1'b1; dap.dap_op = OpRdState; dap.dap_wdata = '0;
    #1;
    checks++; if (dap.dap_ready !== 1'b1) begin errors++; $display("FAIL rd_state_ready got %b want 1", dap.dap_ready); end
    step();
    dap.dap_req = 1'b0;
    checks++; if (dap.dap_resp_vld !== 1'b0) begin errors++; $display("FAIL rd_state_early_vld got %b want 0", dap.dap_resp_vld); end
    step();
    checks++; if ({dap.dap_resp_vld, dap.dap_resp_err} !== 2'b10) begin errors++; $display("FAIL rd_state_resp vld/err got %b want 10", {dap.dap_resp_vld, dap.dap_resp_err}); end
    checks++; if (dap.dap_rdata !== 32'h0000_0002) begin errors++; $display("FAIL rd_state_rdata got %h want 00000002", dap.dap_rdata); end
    step();
    checks++; if (dap.dap_resp_vld !== 1'b0) begin errors++; $display("FAIL rd_state_vld_len got %b want 0", dap.dap_resp_vld); end
    hart_state = '0;
  endtask

  // mode 0: HALT+ack, 1: HALT+nack, 2: RUN with ack and nack together
  task automatic test_cmd(input int mode);
    int hi;
    logic want_err;
    want_err = (mode != 0);
    issue((mode == 2) ? OpRun : OpHalt, '0);
    checks++; if (hart_cmd !== ((mode == 2) ? ModeRun : ModeDbg)) begin errors++; $display("FAIL cmd%0d_mode got %b want %b", mode, hart_cmd, (mode != 2)); end
    hi = 0;
    for (int i = 0; i < 3; i++) begin
      if (hart_cmd_req) hi++;
      if (i == 2) begin
        hart_cmd_ack  = (mode != 1);
        hart_cmd_nack = (mode != 0);
      end
      step();
    end
    hart_cmd_ack = 1'b0; hart_cmd_nack = 1'b0;
    checks++; if (hi != 3 || hart_cmd_req !== 1'b0) begin errors++; $display("FAIL cmd%0d_req high=%0d req_after=%b want 3/0", mode, hi, hart_cmd_req); end
    step();
    checks++; if ({dap.dap_resp_vld, dap.dap_resp_err} !== {1'b1, want_err}) begin errors++; $display("FAIL cmd%0d_resp vld/err got %b want 1%b", mode, {dap.dap_resp_vld, dap.dap_resp_err}, want_err); end
  endtask

  task automatic test_exec(input logic except);
    issue(OpWrRunctrl, 32'h0000_0009);
    step();
    checks++; if (hart_runctrl !== 4'h9) begin errors++; $display("FAIL exec_wr_runctrl got %h want 9", hart_runctrl); end
    hart_state = '{except: 1'b0, halted: 1'b1};
    issue(OpExec, 32'h0010_0073);
    checks++; if (hart_instr !== 32'h0010_0073 || hart_runctrl !== 4'hB || hart_cmd_req !== 1'b1) begin
      errors++; $display("FAIL exec_start instr=%h runctrl=%h req=%b want 00100073/b/1", hart_instr, hart_runctrl, hart_cmd_req);
    end
    hart_cmd_ack = 1'b1; hart_state.halted = 1'b0;
    step();
    hart_cmd_ack = 1'b0;
    checks++; if (hart_cmd_req !== 1'b0 || hart_runctrl !== 4'hB) begin errors++; $display("FAIL exec_acked req=%b runctrl=%h want 0/b", hart_cmd_req, hart_runctrl); end
    hart_state = '{except: except, halted: 1'b1};
    step();
    checks++; if (hart_runctrl !== 4'hB || dap.dap_resp_vld !== 1'b0) begin errors++; $display("FAIL exec_min_wait runctrl=%h vld=%b want b/0", hart_runctrl, dap.dap_resp_vld); end
    step();
    checks++; if (hart_runctrl !== 4'h9) begin errors++; $display("FAIL exec_restore got %h want 9", hart_runctrl); end
    step();
    checks++; if ({dap.dap_resp_vld, dap.dap_resp_err} !== {1'b1, except}) begin errors++; $display("FAIL exec_resp vld/err got %b want 1%b", {dap.dap_resp_vld, dap.dap_resp_err}, except); end
    hart_state = '{except: 1'b0, halted: 1'b1};
  endtask

  task automatic test_exec_running();
    hart_state = '0;
    issue(OpExec, 32'hDEAD_BEEF);
    checks++; if (hart_cmd_req !== 1'b0) begin errors++; $display("FAIL exec_run_req got %b want 0", hart_cmd_req); end
    step();
    checks++; if ({dap.dap_resp_vld, dap.dap_resp_err} !== 2'b11 || hart_instr !== 32'h0010_0073) begin
      errors++; $display("FAIL exec_run_resp vld/err=%b instr=%h want 11/00100073", {dap.dap_resp_vld, dap.dap_resp_err}, hart_instr);
    end
  endtask

  task automatic test_ddr();
    hart_state = '0;
    hart_dreg_wr = 1'b1; hart_dreg_in = 32'hA5A5_A5A5;
    step();
    hart_dreg_in = 32'h5A5A_5A5A;
    step();
    hart_dreg_wr = 1'b0;
    issue(OpRdState, '0); step();
    checks++; if (dap.dap_rdata !== 32'h8000_0000) begin errors++; $display("FAIL ddr_ovr_set got %h want 80000000", dap.dap_rdata); end
    issue(OpRdDreg, '0); step();
    checks++; if (dap.dap_rdata !== 32'h5A5A_5A5A || dap.dap_resp_err !== 1'b0) begin errors++; $display("FAIL ddr_read got %h err=%b want 5a5a5a5a/0", dap.dap_rdata, dap.dap_resp_err); end
    issue(OpRdState, '0); step();
    checks++; if (dap.dap_rdata !== 32'h0) begin errors++; $display("FAIL ddr_ovr_clr got %h want 0", dap.dap_rdata); end
    hart_dreg_wr = 1'b1; hart_dreg_in = 32'h1111_1111;
    step();
    hart_dreg_in = 32'h2222_2222;
    issue(OpRdDreg, '0);
    hart_dreg_wr = 1'b0;
    step();
    checks++; if (dap.dap_rdata !== 32'h1111_1111) begin errors++; $display("FAIL ddr_same_cycle got %h want 11111111", dap.dap_rdata); end
    issue(OpRdState, '0); step();
    checks++; if (dap.dap_rdata !== 32'h0) begin errors++; $display("FAIL ddr_same_cycle_ovr got %h want 0", dap.dap_rdata); end
    issue(OpRdDreg, '0); step();
    checks++; if (dap.dap_rdata !== 32'h2222_2222) begin errors++; $display("FAIL ddr_new_value got %h want 22222222", dap.dap_rdata); end
    issue(OpWrDreg, 32'hCAFE_F00D);
    checks++; if (hart_dreg_out !== 32'hCAFE_F00D) begin errors++; $display("FAIL ddr_wr_dreg got %h want cafef00d", hart_dreg_out); end
    step();
  endtask

`ifdef SCR1_DBGC_CMD_TIMEOUT_EN
  task automatic test_timeout();
    int hi;
    issue(OpHalt, '0);
    hi = 0;
    while (hart_cmd_req && hi < 20) begin
      hi++;
      step();
    end
    checks++; if (hi != 4) begin errors++; $display("FAIL timeout_req_len got %0d want 4", hi); end
    step();
    checks++; if ({dap.dap_resp_vld, dap.dap_resp_err} !== 2'b11) begin errors++; $display("FAIL timeout_resp vld/err got %b want 11", {dap.dap_resp_vld, dap.dap_resp_err}); end
  endtask
`endif

  task automatic test_reset_mid_cmd();
    int vld_seen;
    issue(OpHalt, '0);
    checks++; if (hart_cmd_req !== 1'b1) begin errors++; $display("FAIL rst_mid_req_before got %b want 1", hart_cmd_req); end
    rst_n = 1'b0;
    #1;
    checks++; if (hart_cmd_req !== 1'b0 || hart_cmd !== ModeRun) begin errors++; $display("FAIL rst_mid_req req=%b cmd=%b want 0/0", hart_cmd_req, hart_cmd); end
    vld_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) rst_n = 1'b1;
      if (dap.dap_resp_vld) vld_seen++;
      step();
    end
    checks++; if (vld_seen != 0 || hart_runctrl !== 4'h0) begin errors++; $display("FAIL rst_mid_state vld_seen=%0d runctrl=%h want 0/0", vld_seen, hart_runctrl); end
  endtask

  initial begin
    dap.dap_req = 1'b0; dap.dap_op = OpRdState; dap.dap_wdata = '0;
    hart_cmd_ack = 1'b0; hart_cmd_nack = 1'b0; hart_state = '0;
    hart_dreg_in = '0; hart_dreg_wr = 1'b0;
    test_reset();
    test_rd_state();
    test_cmd(0);
    test_cmd(1);
    test_cmd(2);
    test_exec(1'b0);
    test_exec(1'b1);
    test_exec_running();
    test_ddr();
`ifdef SCR1_DBGC_CMD_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_cmd();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
